// File: rtl/clock_reset_ctrl.sv
// ---------------------------------------------------------------------------
// clock_reset_ctrl
//   Core reset sequencer and clock-enable generator for a 49.152 MHz system
//   clock. The PLL lock flag is double-synchronized, then it must stay high
//   (with no soft reset) for STRETCH_CYCLES cycles before the core leaves
//   reset. While running, a free-running 5-bit phase counter produces the
//   pixel (/8), CPU (/16) and sound (/32) enables. The CPU and sound enables
//   can be frozen by pause without disturbing the phase grid.
//
// Ports
//   clk_sys     in  system clock, sole clock of the block
//   rst         in  asynchronous active-high reset
//   pll_locked  in  PLL lock flag, asynchronous to clk_sys
//   soft_reset  in  synchronous reset request (OSD / ROM download)
//   pause       in  synchronous CPU/sound freeze request
//   core_reset  out active-high reset to the game core (registered)
//   ce_pix      out 6.144 MHz pixel clock enable, one-cycle pulse
//   ce_cpu      out 3.072 MHz main CPU clock enable, one-cycle pulse
//   ce_snd      out 1.536 MHz sound CPU clock enable, one-cycle pulse
// ---------------------------------------------------------------------------
module clock_reset_ctrl #(
  parameter int unsigned STRETCH_CYCLES = 1024
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic pll_locked,
  input  logic soft_reset,
  input  logic pause,
  output logic core_reset,
  output logic ce_pix,
  output logic ce_cpu,
  output logic ce_snd
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RUN     = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(STRETCH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic        locked_s;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  phase_q, phase_d;
  logic        core_reset_q;
  logic        abort;
  logic        run;

  assign locked_s = sync_q[1];
  // Any loss of lock or soft request restarts the whole sequence.
  assign abort    = !locked_s || soft_reset;
  assign run      = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      HOLD: begin
        cnt_d = '0;
        if (!abort) state_d = STRETCH;
      end
      STRETCH: begin
        // Abort is tested first so it wins over completion in the same cycle.
        if (abort) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (abort) state_d = HOLD;
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // Phase only advances between two consecutive RUN cycles, so the first
    // RUN cycle always sees phase 0 and any non-RUN cycle sees phase 0.
    if (run && (state_d == RUN)) phase_d = phase_q + 5'd1;
    else                         phase_d = '0;
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      state_q      <= HOLD;
      cnt_q        <= '0;
      phase_q      <= '0;
      core_reset_q <= 1'b1;
    end else begin
      sync_q       <= {sync_q[0], pll_locked};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      core_reset_q <= (state_d != RUN);
    end
  end

  assign core_reset = core_reset_q;

  // Enables decode the current phase; pause gates CPU/sound combinationally
  // but never touches the phase counter, so the grid is preserved.
  assign ce_pix = run && (phase_q[2:0] == 3'd7);
  assign ce_cpu = run && (phase_q[3:0] == 4'd15) && !pause;
  assign ce_snd = run && (phase_q      == 5'd31) && !pause;

endmodule

// File: tb/tb_clock_reset_ctrl.sv
module tb_clock_reset_ctrl;

  localparam int N = 1024;

  logic clk_sys = 1'b0;
  logic rst, pll_locked, soft_reset, pause;
  logic core_reset, ce_pix, ce_cpu, ce_snd;

  int checks = 0;
  int errors = 0;

  clock_reset_ctrl #(.STRETCH_CYCLES(N)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .pause     (pause),
    .core_reset(core_reset),
    .ce_pix    (ce_pix),
    .ce_cpu    (ce_cpu),
    .ce_snd    (ce_snd)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: the core runs once the last N+1 edge samples of
  // (lock seen two edges late AND no soft reset) were all good. Phase is the
  // number of RUN cycles so far, modulo 32.
  int   streak;
  logic s1, s2;

  always @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      streak <= 0;
      s1     <= 1'b0;
      s2     <= 1'b0;
    end else begin
      streak <= (s2 && !soft_reset) ? streak + 1 : 0;
      s2     <= s1;
      s1     <= pll_locked;
    end
  end

  function automatic logic [3:0] model_out(input int stk, input logic pz, input logic r);
    int  ph;
    logic m_run;
    m_run = !r && (stk >= N + 1);
    ph    = m_run ? (stk - (N + 1)) % 32 : 0;
    return {!m_run,
            m_run && (ph % 8 == 7),
            m_run && (ph % 16 == 15) && !pz,
            m_run && (ph == 31) && !pz};
  endfunction

  always @(negedge clk_sys) begin
    check("cycle", {28'd0, core_reset, ce_pix, ce_cpu, ce_snd},
          {28'd0, model_out(streak, pause, rst)});
  end

  // Waits for core_reset to reach val; returns edges counted (limit on timeout).
  task automatic wait_core(input logic val, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk_sys);
      n++;
      @(negedge clk_sys);
      if (core_reset === val) return;
    end
    check("wait_core_timeout", 32'(n), 32'(limit + 1));
  endtask

  initial begin
    int n, n2, first_pix, cpix, ccpu, csnd, k;

    rst = 1'b1; pll_locked = 1'b1; soft_reset = 1'b0; pause = 1'b0;

    // Power-up
    repeat (5) @(posedge clk_sys);
    @(negedge clk_sys);
    check("reset_outputs", {28'd0, core_reset, ce_pix, ce_cpu, ce_snd}, 32'h8);
    @(posedge clk_sys); #1 rst = 1'b0;
    wait_core(1'b0, 3000, n);
    check("powerup_release_edges", 32'(n), 32'd1027);

    // Steady RUN: 256 cycles starting with the first RUN cycle
    first_pix = -1; cpix = 0; ccpu = 0; csnd = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk_sys);
      if (ce_pix) begin
        cpix++;
        if (first_pix < 0) first_pix = i;
      end
      if (ce_cpu) ccpu++;
      if (ce_snd) csnd++;
    end
    check("first_pix_index", 32'(first_pix), 32'd7);
    check("pix_count", 32'(cpix), 32'd32);
    check("cpu_count", 32'(ccpu), 32'd16);
    check("snd_count", 32'(csnd), 32'd8);

    // One-cycle lock glitch
    @(posedge clk_sys); #1 pll_locked = 1'b0;
    @(posedge clk_sys); #1 pll_locked = 1'b1;
    wait_core(1'b1, 10, n);
    check("glitch_assert_edges", 32'(n + 1), 32'd3);
    wait_core(1'b0, 2000, n2);
    check("glitch_release_edges", 32'(n + 1 + n2), 32'd1028);

    // Soft reset pulse at stretch count 500
    @(posedge clk_sys); #1 soft_reset = 1'b1;
    @(posedge clk_sys); #1 soft_reset = 1'b0;
    repeat (501) @(posedge clk_sys);
    #1 soft_reset = 1'b1;
    @(posedge clk_sys); #1 soft_reset = 1'b0;
    wait_core(1'b0, 2000, n);
    check("soft_release_edges", 32'(n), 32'd1025);

    // Pause for 40 cycles starting right after a CPU enable
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!ce_cpu && k < 64);
    check("found_cpu_before_pause", 32'(ce_cpu), 32'd1);
    @(posedge clk_sys); #1 pause = 1'b1;
    cpix = 0; ccpu = 0; csnd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (ce_pix) cpix++;
      if (ce_cpu) ccpu++;
      if (ce_snd) csnd++;
    end
    @(posedge clk_sys); #1 pause = 1'b0;
    check("pause_pix_count", 32'(cpix), 32'd5);
    check("pause_cpu_count", 32'(ccpu), 32'd0);
    check("pause_snd_count", 32'(csnd), 32'd0);
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!ce_cpu && k < 64);
    check("resume_cpu_cycle", 32'(k), 32'd8);
    check("resume_snd_with_cpu", 32'(ce_snd), 32'd1);

    // Asynchronous reset between edges while a pixel enable is high
    k = 0;
    do begin
      @(negedge clk_sys);
      k++;
    end while (!ce_pix && k < 16);
    check("found_pix_before_rst", 32'(ce_pix), 32'd1);
    #1 rst = 1'b1;
    #1 check("async_rst_outputs", {28'd0, core_reset, ce_pix, ce_cpu, ce_snd}, 32'h8);
    @(posedge clk_sys); #1 rst = 1'b0;

    // Randomized traffic checked cycle by cycle against the model
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk_sys);
      #1;
      pause      = 1'($urandom_range(1, 0));
      soft_reset = ($urandom_range(5999, 0) == 0);
      pll_locked = ($urandom_range(5999, 0) != 0);
      rst        = ($urandom_range(7999, 0) == 0);
    end
    @(posedge clk_sys); #1 rst = 1'b0;
    @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
